// File: rtl/wrap_counter_pkg.sv
// Shared core configuration: queue depths, pointer increment widths
// and the width helper used by the queue-pointer counters.
package wrap_counter_pkg;

  localparam int ROB_DEPTH  = 48;
  localparam int IQ_DEPTH   = 24;
  localparam int LSQ_DEPTH  = 20;

  localparam int DISPATCH_W = 4;
  localparam int COMMIT_W   = 4;

  function automatic int clog2_f1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wrap_counter_mod_adder.sv
// Combinational modulo-DEPTH add of a pre-clamped increment.
module mod_adder #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   i,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam logic [WIDTH:0] DEPTH_V = (WIDTH+1)'(DEPTH);

  logic [WIDTH:0] s;

  assign s    = {1'b0, count} + i;
  assign wrap = (s >= DEPTH_V);
  // The result fits in WIDTH bits, so the subtract can run mod 2^WIDTH.
  assign next = wrap ? (s[WIDTH-1:0] - DEPTH_V[WIDTH-1:0])
                     : s[WIDTH-1:0];

endmodule

// File: rtl/wrap_counter_reg.sv
// Register primitive: asynchronous active-low reset to zero.
module prim_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_aL,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) q <= '0;
    else         q <= d;
  end

endmodule

// File: rtl/wrap_counter.sv
// Modulo-DEPTH multi-increment pointer with load and wrap pulse.
// Phase flop present only when WRAP_COUNTER_PHASE_EN is defined.
module wrap_counter
  import wrap_counter_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int MAX_INC = 1,
  localparam int WIDTH   = clog2_f1(DEPTH),
  localparam int INC_W   = $clog2(MAX_INC + 1)
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_phase,
  output logic [WIDTH-1:0] count,
  output logic             phase,
  output logic             wrapped
);

  localparam logic [WIDTH:0]   DEPTH_V = (WIDTH+1)'(DEPTH);
  localparam logic [INC_W-1:0] MAX_V   = INC_W'(MAX_INC);

  logic [INC_W-1:0] inc_c;
  logic [WIDTH:0]   i;
  logic [WIDTH-1:0] sum;
  logic             wrap;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_d;
  logic             lv_ok;

  assign inc_c = (inc > MAX_V) ? MAX_V : inc;
  assign i     = (WIDTH+1)'(inc_c);
  assign lv_ok = ({1'b0, load_val} < DEPTH_V);

  mod_adder #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_add (
    .count (count),
    .i     (i),
    .next  (sum),
    .wrap  (wrap)
  );

  always_comb begin
    count_d   = count;
    wrapped_d = 1'b0;
    unique case (1'b1)
      load: begin
        count_d = lv_ok ? load_val : '0;
      end
      (en && !load): begin
        count_d   = sum;
        wrapped_d = wrap;
      end
      default: ;
    endcase
  end

  prim_reg #(.W(WIDTH)) u_count (
    .clk    (clk),
    .rst_aL (rst_aL),
    .d      (count_d),
    .q      (count)
  );

  prim_reg #(.W(1)) u_wrapped (
    .clk    (clk),
    .rst_aL (rst_aL),
    .d      (wrapped_d),
    .q      (wrapped)
  );

`ifdef WRAP_COUNTER_PHASE_EN
  logic phase_d;

  assign phase_d = load        ? load_phase :
                   (en & wrap) ? ~phase     :
                                 phase;

  prim_reg #(.W(1)) u_phase (
    .clk    (clk),
    .rst_aL (rst_aL),
    .d      (phase_d),
    .q      (phase)
  );
`else
  logic unused_load_phase;

  assign unused_load_phase = load_phase;
  assign phase             = 1'b0;
`endif

endmodule

// File: tb/tb_wrap_counter.sv
// Scoreboard bench for wrap_counter at three DEPTH/MAX_INC points.
module tb_wrap_counter;

`ifdef WRAP_COUNTER_PHASE_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] count;
    logic        phase;
    logic        wrapped;
  } exp_t;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic       a_en = 0, a_ld = 0, a_lp = 0;
  logic [1:0] a_inc = 0;
  logic [2:0] a_lv = 0, a_cnt;
  logic       a_ph, a_w;

  logic       b_en = 0, b_ld = 0, b_lp = 0;
  logic [2:0] b_inc = 0, b_lv = 0, b_cnt;
  logic       b_ph, b_w;

  logic       c_en = 0, c_ld = 0, c_lp = 0;
  logic [2:0] c_inc = 0, c_lv = 0, c_cnt;
  logic       c_ph, c_w;

  wrap_counter #(.DEPTH(6), .MAX_INC(2)) u_a (
    .clk (clk), .rst_aL (rst_aL),
    .en (a_en), .inc (a_inc),
    .load (a_ld), .load_val (a_lv),
    .load_phase (a_lp),
    .count (a_cnt), .phase (a_ph),
    .wrapped (a_w)
  );

  wrap_counter #(.DEPTH(8), .MAX_INC(4)) u_b (
    .clk (clk), .rst_aL (rst_aL),
    .en (b_en), .inc (b_inc),
    .load (b_ld), .load_val (b_lv),
    .load_phase (b_lp),
    .count (b_cnt), .phase (b_ph),
    .wrapped (b_w)
  );

  wrap_counter #(.DEPTH(5), .MAX_INC(5)) u_c (
    .clk (clk), .rst_aL (rst_aL),
    .en (c_en), .inc (c_inc),
    .load (c_ld), .load_val (c_lv),
    .load_phase (c_lp),
    .count (c_cnt), .phase (c_ph),
    .wrapped (c_w)
  );

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int c, input bit p,
                              input bit w);
    exp_t x;
    x.count   = 16'(c);
    x.phase   = p & PH;
    x.wrapped = w;
    return x;
  endfunction

  // Monitor: outputs are presented every cycle, sampled 1 after the edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      chk("a_count", int'(a_cnt), int'(x.count));
      chk("a_phase", int'(a_ph), int'(x.phase));
      chk("a_wrapped", int'(a_w), int'(x.wrapped));
    end
    if (qb.size() > 0) begin
      x = qb.pop_front();
      chk("b_count", int'(b_cnt), int'(x.count));
      chk("b_phase", int'(b_ph), int'(x.phase));
      chk("b_wrapped", int'(b_w), int'(x.wrapped));
    end
    if (qc.size() > 0) begin
      x = qc.pop_front();
      chk("c_count", int'(c_cnt), int'(x.count));
      chk("c_range", int'(c_cnt < 3'd5), 1);
      chk("c_phase", int'(c_ph), int'(x.phase));
      chk("c_wrapped", int'(c_w), int'(x.wrapped));
    end
  end

  task automatic step_a(input bit e, input int inc, input bit ld,
                        input int lv, input bit lp, input int ec,
                        input bit ep, input bit ew);
    @(negedge clk);
    a_en = e; a_inc = 2'(inc); a_ld = ld;
    a_lv = 3'(lv); a_lp = lp;
    qa.push_back(mk(ec, ep, ew));
  endtask

  task automatic step_b(input bit e, input int inc, input bit ld,
                        input int lv, input bit lp, input int ec,
                        input bit ep, input bit ew);
    @(negedge clk);
    b_en = e; b_inc = 3'(inc); b_ld = ld;
    b_lv = 3'(lv); b_lp = lp;
    qb.push_back(mk(ec, ep, ew));
  endtask

  task automatic step_c(input bit e, input int inc, input bit ld,
                        input int lv, input bit lp, input int ec,
                        input bit ep, input bit ew);
    @(negedge clk);
    c_en = e; c_inc = 3'(inc); c_ld = ld;
    c_lv = 3'(lv); c_lp = lp;
    qc.push_back(mk(ec, ep, ew));
  endtask

  task automatic quiet();
    @(negedge clk);
    a_en = 0; a_ld = 0;
    b_en = 0; b_ld = 0;
    c_en = 0; c_ld = 0;
  endtask

  initial begin
    int  cnt;
    int  i;
    bit  ph;
    bit  w;
    bit  ld, e, lp;
    int  inc, lv;

    #1;
    chk("rst_a_count", int'(a_cnt), 0);
    chk("rst_a_phase", int'(a_ph), 0);
    chk("rst_a_wrapped", int'(a_w), 0);
    chk("rst_b_count", int'(b_cnt), 0);
    #11 rst_aL = 1'b1;

    // DEPTH=6, MAX_INC=2: 2,2,1 then wrap, then no pulse
    step_a(1, 2, 0, 0, 0, 2, 0, 0);
    step_a(1, 2, 0, 0, 0, 4, 0, 0);
    step_a(1, 1, 0, 0, 0, 5, 0, 0);
    step_a(1, 2, 0, 0, 0, 1, 1, 1);
    step_a(1, 1, 0, 0, 0, 2, 1, 0);
    // exact landing, inc=0, hold
    step_a(0, 0, 1, 4, 0, 4, 0, 0);
    step_a(1, 2, 0, 0, 0, 0, 1, 1);
    step_a(0, 0, 1, 5, 0, 5, 0, 0);
    step_a(1, 0, 0, 0, 0, 5, 0, 0);
    step_a(0, 2, 0, 0, 1, 5, 0, 0);
    // load priority, out-of-range load, load clears pulse
    step_a(0, 0, 1, 3, 0, 3, 0, 0);
    step_a(1, 2, 1, 1, 1, 1, 1, 0);
    step_a(1, 2, 1, 7, 0, 0, 0, 0);
    step_a(0, 0, 1, 5, 0, 5, 0, 0);
    step_a(1, 2, 0, 0, 0, 1, 1, 1);
    step_a(1, 2, 1, 2, 0, 2, 0, 0);
    quiet();

    // DEPTH=8, MAX_INC=4: inc=7 clamps to 4
    step_b(0, 0, 1, 6, 0, 6, 0, 0);
    step_b(1, 7, 0, 0, 0, 2, 1, 1);
    step_b(1, 7, 0, 0, 0, 6, 1, 0);
    step_b(1, 4, 0, 0, 0, 2, 0, 1);
    step_b(1, 5, 0, 0, 0, 6, 0, 0);
    step_b(1, 2, 0, 0, 0, 0, 1, 1);
    quiet();

    // asynchronous reset in mid-cycle
    step_a(0, 0, 1, 3, 1, 3, 1, 0);
    quiet();
    @(posedge clk);
    #2 rst_aL = 1'b0;
    #1;
    chk("mid_rst_count", int'(a_cnt), 0);
    chk("mid_rst_phase", int'(a_ph), 0);
    chk("mid_rst_wrapped", int'(a_w), 0);
    @(negedge clk);
    rst_aL = 1'b1;

    // DEPTH=5, MAX_INC=5: back-to-back wraps keep the pulse high
    step_c(0, 0, 1, 4, 0, 4, 0, 0);
    step_c(1, 5, 0, 0, 0, 4, 1, 1);
    step_c(1, 7, 0, 0, 0, 4, 0, 1);
    step_c(1, 0, 0, 0, 0, 4, 0, 0);
    step_c(0, 0, 1, 0, 0, 0, 0, 0);

    cnt = 0;
    ph  = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      ld  = ($urandom_range(7) == 0);
      e   = 1'($urandom_range(1));
      inc = int'($urandom_range(7));
      lv  = int'($urandom_range(7));
      lp  = 1'($urandom_range(1));
      w   = 1'b0;
      if (ld) begin
        cnt = (lv < 5) ? lv : 0;
        ph  = lp;
      end else if (e) begin
        i   = (inc > 5) ? 5 : inc;
        w   = ((cnt + i) >= 5);
        cnt = (cnt + i) % 5;
        if (w) ph = ~ph;
      end
      step_c(e, inc, ld, lv, lp, cnt, ph, w);
    end
    quiet();

    repeat (3) @(posedge clk);
    #2;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
